// File: rtl/fetch_ctrl_pkg.sv
// Shared CPU definitions: reset/base constants and the IF/ID payload struct.
package cpu_defs;

  localparam logic [31:0]  RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0]  IM_BASE_DEF  = 32'h0000_3000;
  localparam int unsigned  IM_WORDS_DEF = 1024;
  localparam logic [31:0]  NOP_INSTR    = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic        valid;
    logic        exc;
  } if_id_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bus: hazard/branch requests, instruction memory port and IF/ID view.
interface fetch_ctrl_if;

  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] im_addr;
  logic [31:0] im_rdata;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc8;
  logic        if_id_valid;
  logic        if_id_exc;
  logic [31:0] fetch_count;

  // Environment side: hazard unit, branch logic and instruction memory.
  modport master (
    output stall, flush, redirect_valid, redirect_pc, im_rdata,
    input  im_addr, pc, if_id_instr, if_id_pc, if_id_pc8, if_id_valid,
           if_id_exc, fetch_count
  );

  // Fetch controller side.
  modport slave (
    input  stall, flush, redirect_valid, redirect_pc, im_rdata,
    output im_addr, pc, if_id_instr, if_id_pc, if_id_pc8, if_id_valid,
           if_id_exc, fetch_count
  );

endinterface

// File: rtl/fetch_ctrl_if_id_reg.sv
// IF/ID pipeline register; flush outranks stall, and flush keeps pc/pc8.
module if_id_reg
  import cpu_defs::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   i_flush,
  input  logic   i_stall,
  input  if_id_t i_d,
  output if_id_t o_q
);

  if_id_t r_q;

  // Register update with reset > flush > stall > load priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (i_flush) begin
      r_q.instr <= NOP_INSTR;
      r_q.valid <= 1'b0;
      r_q.exc   <= 1'b0;
    end else if (!i_stall) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: PC, pending-redirect latch, fault detect and fetch counter.
module fetch_ctrl
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
  parameter int unsigned IM_WORDS = IM_WORDS_DEF
) (
  input  logic         clk,
  input  logic         reset,
  fetch_ctrl_if.slave  bus
);

  // One past the last mapped byte; 33 bits so the bound cannot wrap.
  localparam logic [32:0] IM_END = 33'(IM_BASE) + (33'(IM_WORDS) << 2);

  logic [31:0] r_pc;
  logic        r_pend;
  logic [31:0] r_pend_pc;
  logic [31:0] r_fetch_count;

  logic [31:0] w_pc_nxt;
  logic        w_pend_nxt;
  logic [31:0] w_pend_pc_nxt;
  logic        w_bad;
  logic        w_load;
  logic [31:0] w_fetch_word;
  if_id_t      w_if_id_d;
  if_id_t      w_if_id_q;

  // Misaligned or out-of-window fetch address raises AdEL.
  always_comb begin
    w_bad        = (r_pc[1:0] != 2'b00) || (r_pc < IM_BASE) || (33'(r_pc) >= IM_END);
    w_fetch_word = w_bad ? NOP_INSTR : bus.im_rdata;
    w_load       = !bus.flush && !bus.stall;
  end

  // PC next-state; a redirect seen during stall is parked in the pending latch.
  always_comb begin
    w_pc_nxt      = r_pc + 32'd4;
    w_pend_nxt    = r_pend;
    w_pend_pc_nxt = r_pend_pc;
    if (bus.stall && bus.redirect_valid) begin
      w_pc_nxt      = r_pc;
      w_pend_nxt    = 1'b1;
      w_pend_pc_nxt = bus.redirect_pc;
    end else if (bus.stall) begin
      w_pc_nxt      = r_pc;
    end else if (bus.redirect_valid) begin
      w_pc_nxt      = bus.redirect_pc;
      w_pend_nxt    = 1'b0;
    end else if (r_pend) begin
      w_pc_nxt      = r_pend_pc;
      w_pend_nxt    = 1'b0;
    end
  end

  // PC, pending latch and fetch counter state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_pend        <= 1'b0;
      r_pend_pc     <= 32'd0;
      r_fetch_count <= 32'd0;
    end else begin
      r_pc      <= w_pc_nxt;
      r_pend    <= w_pend_nxt;
      r_pend_pc <= w_pend_pc_nxt;
      if (w_load) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
    end
  end

  // IF/ID payload built from the word currently being fetched.
  always_comb begin
    w_if_id_d.instr = w_fetch_word;
    w_if_id_d.pc    = r_pc;
    w_if_id_d.pc8   = r_pc + 32'd8;
    w_if_id_d.valid = 1'b1;
    w_if_id_d.exc   = w_bad;
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .reset   (reset),
    .i_flush (bus.flush),
    .i_stall (bus.stall),
    .i_d     (w_if_id_d),
    .o_q     (w_if_id_q)
  );

  assign bus.im_addr     = r_pc - IM_BASE;
  assign bus.pc          = r_pc;
  assign bus.if_id_instr = w_if_id_q.instr;
  assign bus.if_id_pc    = w_if_id_q.pc;
  assign bus.if_id_pc8   = w_if_id_q.pc8;
  assign bus.if_id_valid = w_if_id_q.valid;
  assign bus.if_id_exc   = w_if_id_q.exc;
  assign bus.fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with an IF/ID expectation scoreboard.
module tb_fetch_ctrl;
  import cpu_defs::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  logic [31:0] mem [0:1023];
  if_id_t      sb [$];

  fetch_ctrl_if bus ();

  fetch_ctrl u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  assign bus.im_rdata = mem[bus.im_addr[11:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] p);
    logic [31:0] off;
    off = p - 32'h0000_3000;
    return 32'h1000_0000 + {2'b00, off[31:2]};
  endfunction

  function automatic if_id_t mk(input logic [31:0] instr, input logic [31:0] pc,
                                input logic [31:0] pc8, input logic valid,
                                input logic exc);
    if_id_t e;
    e.instr = instr;
    e.pc    = pc;
    e.pc8   = pc8;
    e.valid = valid;
    e.exc   = exc;
    return e;
  endfunction

  function automatic if_id_t ld(input logic [31:0] p);
    return mk(word_at(p), p, p + 32'd8, 1'b1, 1'b0);
  endfunction

  function automatic if_id_t ld_exc(input logic [31:0] p);
    return mk(32'h0, p, p + 32'd8, 1'b1, 1'b1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Queue the expected IF/ID, take one edge, then compare everything visible.
  task automatic step(input string tag, input if_id_t exp_ifid,
                      input logic [31:0] exp_pc, input logic [31:0] exp_cnt);
    if_id_t e;
    sb.push_back(exp_ifid);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".instr"}, bus.if_id_instr, e.instr);
    chk({tag, ".ifpc"},  bus.if_id_pc,    e.pc);
    chk({tag, ".pc8"},   bus.if_id_pc8,   e.pc8);
    chk({tag, ".valid"}, 32'(bus.if_id_valid), 32'(e.valid));
    chk({tag, ".exc"},   32'(bus.if_id_exc),   32'(e.exc));
    chk({tag, ".pc"},    bus.pc,          exp_pc);
    chk({tag, ".imaddr"}, bus.im_addr,    exp_pc - 32'h0000_3000);
    chk({tag, ".count"}, bus.fetch_count, exp_cnt);
  endtask

  task automatic drive(input logic st, input logic fl, input logic rv,
                       input logic [31:0] rp);
    bus.stall          = st;
    bus.flush          = fl;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rp;
  endtask

  initial begin
    if_id_t zero;
    if_id_t held;
    checks   = 0;
    failures = 0;
    zero     = mk(32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int k = 0; k < 1024; k++) mem[k] = 32'h1000_0000 + 32'(k);

    // Reset edge
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step("rst", zero, 32'h3000, 32'd0);
    reset = 1'b0;

    // Free-running fetch
    step("f0", ld(32'h3000), 32'h3004, 32'd1);
    step("f1", ld(32'h3004), 32'h3008, 32'd2);

    // Redirect: delay-slot word at 3008 still loads
    drive(1'b0, 1'b0, 1'b1, 32'h3040);
    step("rd0", ld(32'h3008), 32'h3040, 32'd3);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step("rd1", ld(32'h3040), 32'h3044, 32'd4);

    // Stall with redirect, overwritten by a later redirect in the same stall
    held = ld(32'h3040);
    drive(1'b1, 1'b0, 1'b1, 32'h3080);
    step("st0", held, 32'h3044, 32'd4);
    drive(1'b1, 1'b0, 1'b1, 32'h3100);
    step("st1", held, 32'h3044, 32'd4);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step("st2", ld(32'h3044), 32'h3100, 32'd5);
    step("st3", ld(32'h3100), 32'h3104, 32'd6);

    // Flush with stall: bubble, pc/pc8 retained, PC holds
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    step("fs0", mk(32'h0, 32'h3100, 32'h3108, 1'b0, 1'b0), 32'h3104, 32'd6);
    // Flush alone: PC advances, nothing counted
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    step("fs1", mk(32'h0, 32'h3100, 32'h3108, 1'b0, 1'b0), 32'h3108, 32'd6);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step("fs2", ld(32'h3108), 32'h310C, 32'd7);

    // Fetch faults: misaligned, above window, below window
    drive(1'b0, 1'b0, 1'b1, 32'h3002);
    step("ex0", ld(32'h310C), 32'h3002, 32'd8);
    drive(1'b0, 1'b0, 1'b1, 32'h4000);
    step("ex1", ld_exc(32'h3002), 32'h4000, 32'd9);
    drive(1'b0, 1'b0, 1'b1, 32'h2FFC);
    step("ex2", ld_exc(32'h4000), 32'h2FFC, 32'd10);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step("ex3", ld_exc(32'h2FFC), 32'h3000, 32'd11);
    step("ex4", ld(32'h3000), 32'h3004, 32'd12);

    // Reset while a redirect is pending in a stall
    held = ld(32'h3000);
    drive(1'b1, 1'b0, 1'b1, 32'h3200);
    step("rp0", held, 32'h3004, 32'd12);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    step("rp1", zero, 32'h3000, 32'd0);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step("rp2", ld(32'h3000), 32'h3004, 32'd1);
    step("rp3", ld(32'h3004), 32'h3008, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
